// File: rtl/q_sweep_sequencer.sv
// Steps a Q controller through a setpoint table: apply, wait for convergence or timeout, reset pulse, gap.
// Define Q_SWEEP_CONV_HOLD_EN to require HOLD_CYCLES consecutive converged cycles before an entry passes.
module q_sweep_sequencer #(
    parameter int BUS_WIDTH      = 10,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int RST_CYCLES     = 5,
    parameter int HOLD_CYCLES    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     start,
    input  logic                     converged,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [BUS_WIDTH-1:0]     cfg_data,
    output logic [BUS_WIDTH-1:0]     q_desired,
    output logic                     ctrl_rst,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic [DEPTH-1:0]         pass_mask
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RCW = $clog2(RST_CYCLES + 1);

    localparam logic [AW-1:0]  IDX_LAST  = AW'(DEPTH - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);
    localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        RPULSE,
        GAP,
        DONE
    } state_t;

    state_t                state_q;
    logic [BUS_WIDTH-1:0]  table_q [DEPTH];
    logic [BUS_WIDTH-1:0]  q_desired_q;
    logic                  ctrl_rst_q;
    logic                  busy_q;
    logic                  done_q;
    logic [AW-1:0]         idx_q;
    logic [AW-1:0]         idx_d;
    logic [DEPTH-1:0]      pass_mask_q;
    logic [WCW-1:0]        wait_cnt_q;
    logic [WCW-1:0]        wait_cnt_d;
    logic [RCW-1:0]        rst_cnt_q;
    logic [RCW-1:0]        rst_cnt_d;
    logic                  conv_qual;

    always_comb begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        rst_cnt_d  = rst_cnt_q + 1'b1;
        idx_d      = idx_q + 1'b1;
    end

`ifdef Q_SWEEP_CONV_HOLD_EN
    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    logic [HCW-1:0] hold_cnt_q;

    assign conv_qual = converged && (hold_cnt_q == HOLD_LAST);

    // Counts the current run of converged=1 inside WAIT; any gap restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else if (state_q != WAIT || !converged || !enable) begin
            hold_cnt_q <= '0;
        end else if (!conv_qual) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end
`else
    logic unused_hold_cfg;

    assign conv_qual       = converged;
    assign unused_hold_cfg = (HOLD_CYCLES == 0);
`endif

    // Table is frozen for the whole sweep so a setpoint cannot change under the controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (cfg_we && !busy_q && (int'(cfg_addr) < DEPTH)) begin
            table_q[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            q_desired_q <= '0;
            ctrl_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            idx_q       <= '0;
            pass_mask_q <= '0;
            wait_cnt_q  <= '0;
            rst_cnt_q   <= '0;
        end else if (state_q != IDLE && !enable) begin
            state_q    <= IDLE;
            ctrl_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wait_cnt_q <= '0;
            rst_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && enable) begin
                        state_q     <= APPLY;
                        busy_q      <= 1'b1;
                        idx_q       <= '0;
                        pass_mask_q <= '0;
                    end
                end
                APPLY: begin
                    q_desired_q <= table_q[idx_q];
                    wait_cnt_q  <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    wait_cnt_q <= wait_cnt_d;
                    if (conv_qual) begin
                        pass_mask_q[idx_q] <= 1'b1;
                        state_q            <= RPULSE;
                        ctrl_rst_q         <= 1'b1;
                        rst_cnt_q          <= '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= RPULSE;
                        ctrl_rst_q <= 1'b1;
                        rst_cnt_q  <= '0;
                    end
                end
                RPULSE: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q    <= GAP;
                        ctrl_rst_q <= 1'b0;
                        rst_cnt_q  <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_d;
                    end
                end
                GAP: begin
                    if (rst_cnt_q == RST_LAST) begin
                        rst_cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_d;
                            state_q <= APPLY;
                        end
                    end else begin
                        rst_cnt_q <= rst_cnt_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    ctrl_rst_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign q_desired = q_desired_q;
    assign ctrl_rst  = ctrl_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign idx       = idx_q;
    assign pass_mask = pass_mask_q;

endmodule

// File: tb/tb_q_sweep_sequencer.sv
// Self-checking bench for q_sweep_sequencer: per-cycle expectations come from a timeline model of the sweep.
module tb_q_sweep_sequencer;

    localparam int BW = 10;
    localparam int DP = 4;
    localparam int TO = 100;
    localparam int RC = 5;
    localparam int HC = 4;
`ifdef Q_SWEEP_CONV_HOLD_EN
    localparam int HOLDM = HC;
`else
    localparam int HOLDM = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          start = 1'b0;
    logic          converged = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_addr = '0;
    logic [BW-1:0] cfg_data = '0;
    logic [BW-1:0] q_desired;
    logic          ctrl_rst;
    logic          busy;
    logic          done;
    logic [1:0]    idx;
    logic [3:0]    pass_mask;

    q_sweep_sequencer #(
        .BUS_WIDTH      (BW),
        .DEPTH          (DP),
        .TIMEOUT_CYCLES (TO),
        .RST_CYCLES     (RC),
        .HOLD_CYCLES    (HC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .start     (start),
        .converged (converged),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .q_desired (q_desired),
        .ctrl_rst  (ctrl_rst),
        .busy      (busy),
        .done      (done),
        .idx       (idx),
        .pass_mask (pass_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          busy;
        logic          crst;
        logic          done;
        logic [BW-1:0] q;
        logic [1:0]    idx;
        logic          chk_idx;
        logic [3:0]    mask;
        logic          conv;
    } step_t;

    step_t         tr[$];
    int            checks = 0;
    int            errors = 0;
    logic [BW-1:0] tbl[DP];
    logic [BW-1:0] m_q = '0;
    logic [3:0]    m_mask = '0;
    int            mk[DP];
    int            mg[DP];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic conv_at(input int i, input int w);
        return (mk[i] >= 0) && (w >= mk[i]) && (w != mg[i]);
    endfunction

    task automatic push(input logic b, input logic cr, input logic dn, input logic [BW-1:0] q,
                        input int ix, input logic ci, input logic [3:0] m, input logic cv);
        step_t s;
        s.busy = b; s.crst = cr; s.done = dn; s.q = q;
        s.idx = 2'(ix); s.chk_idx = ci; s.mask = m; s.conv = cv;
        tr.push_back(s);
    endtask

    // Timeline of one sweep: per entry 1 apply cycle, L wait cycles, RC pulse cycles, RC gap cycles.
    task automatic build_trace();
        logic [BW-1:0] q;
        logic [3:0]    mask;
        int            run;
        int            len;
        logic          pass;
        q = m_q;
        mask = '0;
        tr.delete();
        for (int i = 0; i < DP; i++) begin
            run = 0; len = TO; pass = 1'b0;
            push(1, 0, 0, q, i, 1, mask, 0);
            for (int w = 0; w < TO; w++) begin
                run = conv_at(i, w) ? run + 1 : 0;
                if (run >= HOLDM) begin
                    pass = 1'b1;
                    len = w + 1;
                    break;
                end
            end
            q = tbl[i];
            for (int w = 0; w < len; w++) push(1, 0, 0, q, i, 1, mask, conv_at(i, w));
            if (pass) mask[i] = 1'b1;
            for (int r = 0; r < RC; r++) push(1, 1, 0, q, i, 1, mask, 0);
            for (int r = 0; r < RC; r++) push(1, 0, 0, q, i, 1, mask, 0);
        end
        push(1, 0, 1, q, DP - 1, 1, mask, 0);
        push(0, 0, 0, q, 0, 0, mask, 0);
    endtask

    task automatic write_cfg(input int a, input logic [BW-1:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        tbl[a] = d;
    endtask

    // abort_at: -1 none, -2 random cycle, otherwise the trace cycle in which enable drops.
    task automatic run_sweep(input int abort_at);
        int n;
        int ab;
        build_trace();
        n = tr.size();
        ab = (abort_at == -2) ? $urandom_range(0, n - 2) : abort_at;
        @(negedge clk);
        enable = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int t = 0; t < n; t++) begin
            converged = tr[t].conv;
            start     = tr[t].busy ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_we    = tr[t].busy ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_data  = BW'($urandom);
            if (t == ab) enable = 1'b0;
            @(negedge clk);
            chk("busy", 32'(busy), 32'(tr[t].busy));
            chk("ctrl_rst", 32'(ctrl_rst), 32'(tr[t].crst));
            chk("done", 32'(done), 32'(tr[t].done));
            chk("q_desired", 32'(q_desired), 32'(tr[t].q));
            chk("pass_mask", 32'(pass_mask), 32'(tr[t].mask));
            if (tr[t].chk_idx) chk("idx", 32'(idx), 32'(tr[t].idx));
            if (t == ab) begin
                @(posedge clk);
                #1;
                enable = 1'b1; start = 1'b0; converged = 1'b0; cfg_we = 1'b0;
                @(negedge clk);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_ctrl_rst", 32'(ctrl_rst), 32'd0);
                chk("abort_mask", 32'(pass_mask), 32'(tr[t].mask));
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("abort_no_done", 32'(done), 32'd0);
                    chk("abort_stays_idle", 32'(busy), 32'd0);
                end
                m_q = tr[t].q;
                m_mask = tr[t].mask;
                return;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0; converged = 1'b0; cfg_we = 1'b0;
        m_q = tr[n - 1].q;
        m_mask = tr[n - 1].mask;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q"}, 32'(q_desired), 32'd0);
        chk({tag, "_ctrl_rst"}, 32'(ctrl_rst), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_idx"}, 32'(idx), 32'd0);
        chk({tag, "_mask"}, 32'(pass_mask), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int ap;
        for (int i = 0; i < DP; i++) begin
            tbl[i] = '0; mk[i] = -1; mg[i] = -1;
        end
        #1 rst = 1'b1;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;

        // Nominal sweep: every entry converges 20 cycles after its apply cycle.
        write_cfg(0, 10'd45); write_cfg(1, 10'd70); write_cfg(2, 10'd95); write_cfg(3, 10'd120);
        for (int i = 0; i < DP; i++) begin mk[i] = 19; mg[i] = -1; end
        run_sweep(-1);
        chk("s1_mask", 32'(pass_mask), 32'hF);
        chk("s1_q_final", 32'(q_desired), 32'd120);

        // Entry 2 never converges and must time out after exactly TO wait cycles.
        mk[2] = -1;
        run_sweep(-1);
        chk("s2_mask", 32'(pass_mask), 32'hB);

        // Qualification on the last wait cycle passes; one cycle later times out.
        mk[0] = TO - HOLDM; mk[1] = TO - HOLDM + 1; mk[2] = 5; mk[3] = TO - HOLDM;
        run_sweep(-1);
        chk("edge_mask", 32'(pass_mask), 32'hD);

        // Interrupted run: high 3, low 1, then high again.
        mk[0] = 2; mg[0] = 5; mk[1] = 3; mk[2] = 3; mk[3] = 3;
        run_sweep(-1);
        for (int i = 0; i < DP; i++) mg[i] = -1;

        // Enable dropped in the middle of entry 1's reset pulse (entry 1 times out).
        mk[0] = 19; mk[1] = -1; mk[2] = 19; mk[3] = 19;
        build_trace();
        ap = 0;
        for (int t = 0; t < tr.size(); t++) begin
            if (tr[t].idx == 2'd1 && tr[t].crst && tr[t].busy) begin
                ap = t + 2;
                break;
            end
        end
        run_sweep(ap);
        chk("abort_mask_val", 32'(pass_mask), 32'h1);

        mk[1] = 7;
        run_sweep(-1);

        // Asynchronous reset in the middle of a wait.
        @(negedge clk);
        enable = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 10; k++) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DP; i++) tbl[i] = '0;
        m_q = '0; m_mask = '0;
        for (int i = 0; i < DP; i++) mk[i] = 4 + i;
        run_sweep(-1);

        // Randomised sweeps.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DP; i++) begin
                if ($urandom_range(0, 1) == 1) write_cfg(i, BW'($urandom));
                mk[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO + 10));
                mg[i] = ($urandom_range(0, 2) == 0 && mk[i] >= 0) ? mk[i] + int'($urandom_range(0, 5)) : -1;
            end
            run_sweep(($urandom_range(0, 3) == 0) ? -2 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
